sync_fifo: RTL

Synchronous ready/valid FIFO that wraps one `DualPortRam` instance as its storage array and adds pointer, occupancy and prefetch logic. It is the stage directly in front of the RAM: it drives the write and read addresses and turns the RAM's one-cycle registered read into a first-word-fall-through output. It is intended for buffering between core stages, such as a fetch queue or a store buffer, at full throughput of one push and one pop per cycle.

---
 rtl/sync_fifo_pkg.sv | 11 +
 rtl/sync_fifo_ram.sv | 28 ++
 rtl/sync_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Types shared by the sync_fifo slice: the output-stage source selector.
// The FIFO geometry stays local to each module and is derived from ADDR_WIDTH.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        RD_SRC_NONE = 2'd0,
        RD_SRC_RAM  = 2'd1,
        RD_SRC_HOLD = 2'd2
    } rdSrc_e;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// A read of address A at edge k presents mem[A] on o_q during cycle k+1.
module DualPortRam #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wAddr,
    input  logic [XLEN-1:0]       i_dataIn,
    input  logic [ADDR_WIDTH-1:0] i_rAddr,
    output logic [XLEN-1:0]       o_q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [XLEN-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing it would block RAM
    // inference, and the FIFO never reads an entry it has not written.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_wAddr] <= i_dataIn;
        end
        o_q <= mem[i_rAddr];
    end

endmodule : DualPortRam

// File: rtl/sync_fifo.sv
// Ready/valid FIFO around DualPortRam with a first-word-fall-through output
// stage (one in-flight read plus one skid entry). Capacity is DEPTH+1.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [XLEN-1:0]       i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [XLEN-1:0]       o_rd_data,
    output logic [ADDR_WIDTH:0]   o_count
);

    localparam int                DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH:0]   ramCount;
    logic                  inflight;
    logic                  holdValid;
    logic [XLEN-1:0]       holdReg;
    logic [XLEN-1:0]       ramQ;

    logic   push;
    logic   pop;
    logic   issue;
    rdSrc_e rdSrc;

    DualPortRam #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk    (i_clk),
        .i_we     (push),
        .i_wAddr  (wrPtr),
        .i_dataIn (i_wr_data),
        .i_rAddr  (rdPtr),
        .o_q      (ramQ)
    );

    // Handshake flags depend only on registered state, so neither ready nor
    // valid has a combinational path from the opposite side's inputs.
    assign o_wr_ready = (ramCount != FULL_COUNT);
    assign o_rd_valid = holdValid || inflight;

    assign push  = i_wr_valid && o_wr_ready;
    assign pop   = o_rd_valid && i_rd_ready;
    assign issue = (ramCount != '0) && (!o_rd_valid || i_rd_ready);

    assign o_count = ramCount + {{ADDR_WIDTH{1'b0}}, o_rd_valid};

    // NOTE: every always_comb output gets a default first so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        rdSrc     = RD_SRC_NONE;
        o_rd_data = ramQ;
        if (holdValid) begin
            rdSrc     = RD_SRC_HOLD;
            o_rd_data = holdReg;
        end else if (inflight) begin
            rdSrc = RD_SRC_RAM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            ramCount <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (issue) begin
                rdPtr <= rdPtr + 1'b1;
            end
            ramCount <= ramCount + {{ADDR_WIDTH{1'b0}}, push}
                                 - {{ADDR_WIDTH{1'b0}}, issue};
        end
    end

    // Inflight and holdValid are never both set: an issue only happens when
    // the presented entry leaves, and the skid only fills when it does not.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inflight  <= 1'b0;
            holdValid <= 1'b0;
            holdReg   <= '0;
        end else begin
            inflight <= issue;
            if (pop) begin
                holdValid <= 1'b0;
            end else if (rdSrc == RD_SRC_RAM) begin
                holdValid <= 1'b1;
                holdReg   <= ramQ;
            end
        end
    end

endmodule : sync_fifo
